// File: rtl/seqdet_pkg.sv
// seqdet_pkg: shared constants and elaboration-time helpers for seqdet_param.
//   PAT_W_MAX      - largest supported pattern length
//   seqdet_state_w - state register width for a given pattern length
//   seqdet_next    - next state for (state k, input bit b), used to build
//                    the constant transition table in the top level
// The optional match counter is built when SEQDET_COUNT_EN is defined.
package seqdet_pkg;

    localparam int unsigned PAT_W_MAX = 16;

    // States S0..S<pat_w> need pat_w+1 encodings.
    function automatic int unsigned seqdet_state_w(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // KMP transition: longest suffix of (prefix_k, b) that is a prefix of the
    // pattern. A full-length suffix is only possible when b extends prefix_k.
    // Non-overlapping mode treats the match state as S0.
    function automatic int unsigned seqdet_next(
        input logic [PAT_W_MAX-1:0] pattern,
        input int unsigned          pat_w,
        input bit                   overlap,
        input int unsigned          k,
        input bit                   b
    );
        int unsigned         kk;
        int unsigned         len;
        int unsigned         best;
        bit                  ok;
        logic [PAT_W_MAX:0]  s;
        kk   = (k == pat_w && !overlap) ? 0 : k;
        len  = kk + 1;
        best = 0;
        s    = '0;
        // s[0] is the oldest consumed bit, s[kk] is the incoming bit.
        for (int unsigned i = 0; i <= PAT_W_MAX; i++) begin
            if (i < kk) begin
                s[5'(i)] = pattern[4'(pat_w - 1 - i)];
            end else if (i == kk) begin
                s[5'(i)] = b;
            end
        end
        for (int unsigned j = 1; j <= PAT_W_MAX; j++) begin
            if (j <= len && j <= pat_w) begin
                ok = 1'b1;
                for (int unsigned m = 0; m < PAT_W_MAX; m++) begin
                    if (m < j) begin
                        if (s[5'(len - j + m)] != pattern[4'(pat_w - 1 - m)]) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = j;
                end
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seqdet_match_counter.sv
// seqdet_match_counter: saturating match counter with synchronous clear.
//   clk, rstn - clock, synchronous active-low reset
//   clear_i   - load zero; wins over a simultaneous increment
//   inc_i     - count one match
//   count_o   - current count, saturates at all-ones
//   sat_o     - registered all-ones decode of count_o
// Instantiated by seqdet_param only when SEQDET_COUNT_EN is defined.
module seqdet_match_counter
    import seqdet_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic             sat_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             sat_q;

    // Next count: clear first, then saturating increment.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= (count_d == CNT_MAX);
        end
    end

    assign count_o = count_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/seqdet_param.sv
// seqdet_param: parametrised Moore serial pattern detector (MSB first).
//   clk, rstn   - clock, synchronous active-low reset
//   din         - serial data, consumed only when din_valid is 1
//   din_valid   - input qualifier; low cycles stall everything
//   clear       - synchronous clear of the match counter only
//   dout_moore  - registered match flag, 1 while in the match state
//   match_count - saturating count of matches (0 without the counter)
//   count_sat   - registered all-ones decode of match_count
// Define SEQDET_COUNT_EN to build the match counter; otherwise the count
// outputs are tied to zero and clear is ignored.
module seqdet_param
    import seqdet_pkg::*;
#(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             dout_moore,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int unsigned   SW      = seqdet_state_w(PAT_W);
    localparam int unsigned   NTBL    = 1 << SW;
    localparam logic [SW-1:0] S_MATCH = SW'(PAT_W);

    if (PAT_W < 2 || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
        $error("seqdet_param: PAT_W must be in 2..16");
    end

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;
    logic          dout_q;
    logic          illegal_c;
    logic          inc_c;
    logic [SW-1:0] tbl_c [NTBL][2];

    // Constant transition table; unused encodings fall back to S0.
    for (genvar k = 0; k < NTBL; k++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            if (k <= PAT_W) begin : g_legal
                localparam int unsigned NXT =
                    seqdet_next(PAT_W_MAX'(PATTERN), PAT_W, OVERLAP, k, 1'(b));
                assign tbl_c[k][b] = SW'(NXT);
            end else begin : g_illegal
                assign tbl_c[k][b] = '0;
            end
        end
    end

    if (NTBL - 1 > PAT_W) begin : g_chk_illegal
        assign illegal_c = (state_q > S_MATCH);
    end else begin : g_no_illegal
        assign illegal_c = 1'b0;
    end

    // Illegal encodings recover to S0 even while stalled.
    always_comb begin
        state_d = state_q;
        if (illegal_c) begin
            state_d = '0;
        end else if (din_valid) begin
            state_d = tbl_c[state_q][din];
        end
    end

    assign inc_c = din_valid && (state_d == S_MATCH);

    // State and Moore output register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= '0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= (state_d == S_MATCH);
        end
    end

    assign dout_moore = dout_q;

`ifdef SEQDET_COUNT_EN
    seqdet_match_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk     (clk),
        .rstn    (rstn),
        .clear_i (clear),
        .inc_i   (inc_c),
        .count_o (match_count),
        .sat_o   (count_sat)
    );
`else
    logic unused_c;
    assign unused_c    = clear ^ inc_c;
    assign match_count = '0;
    assign count_sat   = 1'b0;
`endif

endmodule
